bus_driver: RTL and testbench

BUS_DRIVER -- requirements
Module: bus_driver

---
 rtl/bus_driver_pkg.sv | 13 +
 rtl/bus_src_mux.sv | 19 +
 rtl/bus_driver.sv | 116 +++++++++++
 tb/tb_bus_driver.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bus_driver_pkg.sv
// Shared select codes and FSM state encoding for the bus driver.
package bus_driver_pkg;

  localparam logic [3:0] SEL_MEM    = 4'd8;
  localparam logic [3:0] SEL_IMM    = 4'd9;
  localparam logic [3:0] SEL_ILL_LO = 4'd10;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/bus_src_mux.sv
// Combinational 8:1 selector over the flattened register-source outputs.
module bus_src_mux #(
  parameter int WIDTH = 8
) (
  input  logic [8*WIDTH-1:0] src_data_i,
  input  logic [2:0]         sel_i,
  output logic [WIDTH-1:0]   dout_o
);

  always_comb begin
    dout_o = '0;
    for (int k = 0; k < 8; k++) begin
      if (sel_i == 3'(k)) begin
        dout_o = src_data_i[WIDTH*k +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/bus_driver.sv
// Drives a registered bus from register sources, an immediate or a timed memory read.
// All outputs registered; the memory path waits in MEM_WAIT until ack or timeout.
module bus_driver
  import bus_driver_pkg::*;
#(
  parameter int MEM_TIMEOUT = 8,
  parameter int WIDTH       = 8
) (
  input  logic               Clk,
  input  logic               RST,
  input  logic               rd_req,
  input  logic [3:0]         rd_sel,
  input  logic [8*WIDTH-1:0] src_data,
  input  logic [WIDTH-1:0]   imm,
  input  logic [WIDTH-1:0]   mem_dout,
  input  logic               mem_ack,
  output logic               mem_rd,
  output logic [WIDTH-1:0]   BusOut,
  output logic               bus_valid,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             mem_rd_q, mem_rd_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] reg_src;

  bus_src_mux #(.WIDTH(WIDTH)) u_src_mux (
    .src_data_i (src_data),
    .sel_i      (rd_sel[2:0]),
    .dout_o     (reg_src)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bus_d    = bus_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    mem_rd_d = 1'b0;
    busy_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          if (rd_sel < SEL_MEM) begin
            bus_d   = reg_src;
            valid_d = 1'b1;
          end else if (rd_sel == SEL_MEM) begin
            mem_rd_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = '0;
            state_d  = ST_MEM_WAIT;
          end else if (rd_sel == SEL_IMM) begin
            bus_d   = imm;
            valid_d = 1'b1;
          end else begin
            bus_d   = '0;
            valid_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        // Ack is checked first so a response on the last allowed cycle still lands.
        if (mem_ack) begin
          bus_d   = mem_dout;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          mem_rd_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      mem_rd_q <= mem_rd_d;
      busy_q   <= busy_d;
    end
  end

  assign BusOut    = bus_q;
  assign bus_valid = valid_q;
  assign err       = err_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_driver.sv
// Directed checks of bus_driver: register/immediate/illegal reads, memory ack, timeout and reset.
module tb_bus_driver;

  localparam int WIDTH = 8;
  localparam int MEM_TIMEOUT = 8;

  logic               Clk = 1'b0;
  logic               RST;
  logic               rd_req;
  logic [3:0]         rd_sel;
  logic [8*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]   imm;
  logic [WIDTH-1:0]   mem_dout;
  logic               mem_ack;
  logic               mem_rd;
  logic [WIDTH-1:0]   BusOut;
  logic               bus_valid;
  logic               busy;
  logic               err;

  int errors = 0;
  int checks = 0;

  bus_driver #(.MEM_TIMEOUT(MEM_TIMEOUT), .WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .RST       (RST),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .src_data  (src_data),
    .imm       (imm),
    .mem_dout  (mem_dout),
    .mem_ack   (mem_ack),
    .mem_rd    (mem_rd),
    .BusOut    (BusOut),
    .bus_valid (bus_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] bus, input logic v,
                         input logic e, input logic rd, input logic bz);
    chk({tag, ".BusOut"}, 32'(BusOut), 32'(bus));
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(v));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(rd));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    RST      = 1'b1;
    rd_req   = 1'b0;
    rd_sel   = 4'd0;
    imm      = 8'd0;
    mem_dout = 8'd0;
    mem_ack  = 1'b0;
    // slice k = 8'h10+k except slice 3 = 24
    src_data = {8'h17, 8'h16, 8'h15, 8'h14, 8'd24, 8'h12, 8'h11, 8'h10};
    tick();
    tick();
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;

    // register source 3
    rd_req = 1'b1; rd_sel = 4'd3;
    tick();
    rd_req = 1'b0;
    chk_all("reg3", 8'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("reg3_hold", 8'd24, 1'b0, 1'b0, 1'b0, 1'b0);

    // register source 7
    rd_req = 1'b1; rd_sel = 4'd7;
    tick();
    rd_req = 1'b0;
    chk_all("reg7", 8'h17, 1'b1, 1'b0, 1'b0, 1'b0);

    // illegal select, then immediate
    rd_req = 1'b1; rd_sel = 4'd12;
    tick();
    rd_req = 1'b0;
    chk_all("illegal", 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("illegal_after", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_req = 1'b1; rd_sel = 4'd9; imm = 8'd20;
    tick();
    rd_req = 1'b0;
    chk_all("imm", 8'd20, 1'b1, 1'b0, 1'b0, 1'b0);

    // memory read acked 3 cycles later; a register request mid-wait is ignored
    rd_req = 1'b1; rd_sel = 4'd8;
    tick();
    rd_req = 1'b0;
    chk_all("mem_c1", 8'd20, 1'b0, 1'b0, 1'b1, 1'b1);
    rd_req = 1'b1; rd_sel = 4'd5;
    tick();
    rd_req = 1'b0;
    chk_all("mem_c2", 8'd20, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("mem_c3", 8'd20, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_ack = 1'b1; mem_dout = 8'd30;
    tick();
    mem_ack = 1'b0;
    chk_all("mem_ack", 8'd30, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("mem_after", 8'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // ack while idle is ignored
    mem_ack = 1'b1; mem_dout = 8'd99;
    tick();
    mem_ack = 1'b0;
    chk_all("idle_ack", 8'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // timeout: 8 wait cycles, then err with BusOut unchanged
    rd_req = 1'b1; rd_sel = 4'd8;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
      chk("to_wait.mem_rd", 32'(mem_rd), 32'd1);
      tick();
    end
    chk_all("to_last", 8'd30, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("timeout", 8'd30, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("timeout_after", 8'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // ack on the timeout cycle wins
    rd_req = 1'b1; rd_sel = 4'd8;
    tick();
    rd_req = 1'b0;
    repeat (MEM_TIMEOUT - 1) tick();
    chk("ack_edge.busy", 32'(busy), 32'd1);
    mem_ack = 1'b1; mem_dout = 8'd55;
    tick();
    mem_ack = 1'b0;
    chk_all("ack_edge", 8'd55, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset two cycles into the wait, then a late ack
    rd_req = 1'b1; rd_sel = 4'd8;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    chk("rst_mid.busy", 32'(busy), 32'd1);
    RST = 1'b1; mem_ack = 1'b1; mem_dout = 8'd77;
    tick();
    RST = 1'b0;
    chk_all("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    mem_ack = 1'b0;
    chk_all("late_ack", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_req = 1'b1; rd_sel = 4'd3;
    tick();
    rd_req = 1'b0;
    chk_all("post_rst_read", 8'd24, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
